// File: rtl/dsbpm_tbt_accumulator_pkg.sv
// Shared types, defaults and width helpers for the turn-by-turn accumulator.
package dsbpm_tbt_accumulator_pkg;

  localparam int CHANNEL_COUNT_DEF = 4;
  localparam int MAG_WIDTH_DEF     = 26;
  localparam int SITE_SPT_DEF      = 100;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SYNC_WAIT = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  // Bit positions of this block's flags in the status register word.
  localparam int STAT_CONFIG_ERROR     = 0;
  localparam int STAT_SYNCED           = 1;
  localparam int STAT_MARKER_MISSING   = 2;
  localparam int STAT_MARKER_MISPLACED = 3;

  // A full turn of maximum-magnitude samples fits without overflow.
  function automatic int acc_width(input int mag_w, input int site_spt);
    return mag_w + $clog2(site_spt);
  endfunction

  function automatic int spt_width(input int site_spt);
    return $clog2(site_spt + 1);
  endfunction

endpackage

// File: rtl/dsbpm_tbt_accumulator_if.sv
// Magnitude stream in, turn sums and status out.
interface dsbpm_tbt_accumulator_if
  import dsbpm_tbt_accumulator_pkg::*;
#(
  parameter int CHANNEL_COUNT = CHANNEL_COUNT_DEF,
  parameter int MAG_WIDTH     = MAG_WIDTH_DEF,
  parameter int SPT_WIDTH     = spt_width(SITE_SPT_DEF),
  parameter int ACC_WIDTH     = acc_width(MAG_WIDTH_DEF, SITE_SPT_DEF)
);
  logic                               enable;
  logic [SPT_WIDTH-1:0]               samplesPerTurn;
  logic                               magValid;
  logic [CHANNEL_COUNT*MAG_WIDTH-1:0] magData;
  logic                               turnMarker;
  logic                               tbtValid;
  logic [CHANNEL_COUNT*ACC_WIDTH-1:0] tbtData;
  logic [31:0]                        tbtTurnCount;
  logic                               markerMissing;
  logic                               markerMisplaced;
  logic                               configError;
  logic                               synced;

  modport master (
    output enable, samplesPerTurn, magValid, magData, turnMarker,
    input  tbtValid, tbtData, tbtTurnCount, markerMissing, markerMisplaced,
           configError, synced
  );

  modport slave (
    input  enable, samplesPerTurn, magValid, magData, turnMarker,
    output tbtValid, tbtData, tbtTurnCount, markerMissing, markerMisplaced,
           configError, synced
  );
endinterface

// File: rtl/dsbpm_tbt_accumulator_chan_acc.sv
// One channel: running turn sum plus the registered result of the last turn.
module dsbpm_tbt_chan_acc #(
  parameter int MAG_WIDTH = 26,
  parameter int ACC_WIDTH = 33
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 add_i,
  input  logic                 commit_i,
  input  logic [MAG_WIDTH-1:0] sample_i,
  output logic [ACC_WIDTH-1:0] sum_o
);
  logic [ACC_WIDTH-1:0] acc_q, acc_d, out_q, out_d, sum;

  // A load restarts the turn at this sample; an add extends it.
  assign sum = (load_i ? '0 : acc_q) + ACC_WIDTH'(sample_i);

  // Next-state: accumulator follows load/add, output latches only on commit.
  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    if (clear_i)              acc_d = '0;
    else if (load_i || add_i) acc_d = sum;
    if (commit_i)             out_d = sum;
  end

  // Accumulator and turn-result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign sum_o = out_q;
endmodule

// File: rtl/dsbpm_tbt_accumulator.sv
// Turn-by-turn accumulator: marker alignment, flywheel and resync control.
//
// state        | meaning
// ST_IDLE      | disabled, counters and accumulators cleared
// ST_SYNC_WAIT | tracking samplesPerTurn, waiting for a marker with a valid config
// ST_RUN       | synced, summing turns, flywheeling through missing markers
module dsbpm_tbt_accumulator
  import dsbpm_tbt_accumulator_pkg::*;
#(
  parameter int CHANNEL_COUNT         = CHANNEL_COUNT_DEF,
  parameter int MAG_WIDTH             = MAG_WIDTH_DEF,
  parameter int SITE_SAMPLES_PER_TURN = SITE_SPT_DEF,
  parameter int SPT_WIDTH             = spt_width(SITE_SAMPLES_PER_TURN),
  parameter int ACC_WIDTH             = acc_width(MAG_WIDTH, SITE_SAMPLES_PER_TURN)
) (
  input logic                     clk,
  input logic                     rst,
  dsbpm_tbt_accumulator_if.slave  bus
);
  logic [1:0]                         rst_sync_q;
  logic                               rst_int;
  state_e                             state_q, state_d;
  logic [SPT_WIDTH-1:0]               cnt_q, cnt_d, spt_q, spt_d, cnt_inc;
  logic [31:0]                        turn_cnt_q, turn_cnt_d;
  logic                               cfg_err_q, cfg_err_d;
  logic                               valid_q, missing_q, misplaced_q;
  logic                               cfg_bad, start, sync_hit;
  logic                               ctl_clear, ctl_load, ctl_add, ctl_commit;
  logic                               ev_missing, ev_misplaced;
  logic [CHANNEL_COUNT*ACC_WIDTH-1:0] tbt_data;

  // Internal reset asserts immediately, releases two clocks after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  assign cfg_bad  = (bus.samplesPerTurn < SPT_WIDTH'(2)) ||
                    (bus.samplesPerTurn > SPT_WIDTH'(SITE_SAMPLES_PER_TURN));
  assign start    = (cnt_q == '0) || bus.turnMarker;
  assign cnt_inc  = start ? SPT_WIDTH'(1) : cnt_q + SPT_WIDTH'(1);
  assign sync_hit = bus.magValid && bus.turnMarker && !cfg_bad;

  // State register.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: enable low wins over everything else.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:      state_d = ST_SYNC_WAIT;
        ST_SYNC_WAIT: if (sync_hit) state_d = ST_RUN;
        ST_RUN:       if (ctl_commit && cfg_bad) state_d = ST_SYNC_WAIT;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath controls and status events decoded from state and the sample.
  always_comb begin
    ctl_clear    = 1'b0;
    ctl_load     = 1'b0;
    ctl_add      = 1'b0;
    ctl_commit   = 1'b0;
    ev_missing   = 1'b0;
    ev_misplaced = 1'b0;
    if (!bus.enable || state_q == ST_IDLE) begin
      ctl_clear = 1'b1;
    end else if (state_q == ST_SYNC_WAIT) begin
      ctl_load = sync_hit;
    end else if (state_q == ST_RUN && bus.magValid) begin
      ctl_load     = start;
      ctl_add      = !start;
      ev_missing   = (cnt_q == '0) && !bus.turnMarker;
      ev_misplaced = (cnt_q != '0) && bus.turnMarker;
      ctl_commit   = (cnt_inc == spt_q);
    end
  end

  // Sample counter, turn length latch, turn counter and config error.
  always_comb begin
    cnt_d      = cnt_q;
    spt_d      = spt_q;
    turn_cnt_d = turn_cnt_q;
    if (ctl_clear) begin
      cnt_d      = '0;
      turn_cnt_d = '0;
    end else begin
      if (state_q == ST_SYNC_WAIT) begin
        spt_d = bus.samplesPerTurn;
        cnt_d = sync_hit ? SPT_WIDTH'(1) : '0;
      end else if (ctl_load || ctl_add) begin
        cnt_d = ctl_commit ? '0 : cnt_inc;
      end
      if (ctl_commit) begin
        spt_d      = bus.samplesPerTurn;
        turn_cnt_d = turn_cnt_q + 32'd1;
      end
    end
    cfg_err_d = (state_d == ST_SYNC_WAIT) && cfg_bad;
  end

  // Control registers and one-cycle strobes.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      cnt_q       <= '0;
      spt_q       <= '0;
      turn_cnt_q  <= '0;
      cfg_err_q   <= 1'b0;
      valid_q     <= 1'b0;
      missing_q   <= 1'b0;
      misplaced_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      spt_q       <= spt_d;
      turn_cnt_q  <= turn_cnt_d;
      cfg_err_q   <= cfg_err_d;
      valid_q     <= ctl_commit;
      missing_q   <= ev_missing;
      misplaced_q <= ev_misplaced;
    end
  end

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_chan
    dsbpm_tbt_chan_acc #(
      .MAG_WIDTH(MAG_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_acc (
      .clk_i   (clk),
      .rst_i   (rst_int),
      .clear_i (ctl_clear),
      .load_i  (ctl_load),
      .add_i   (ctl_add),
      .commit_i(ctl_commit),
      .sample_i(bus.magData[g*MAG_WIDTH +: MAG_WIDTH]),
      .sum_o   (tbt_data[g*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  assign bus.tbtValid        = valid_q;
  assign bus.tbtData         = tbt_data;
  assign bus.tbtTurnCount    = turn_cnt_q;
  assign bus.markerMissing   = missing_q;
  assign bus.markerMisplaced = misplaced_q;
  assign bus.configError     = cfg_err_q;
  assign bus.synced          = (state_q == ST_RUN);
endmodule

// File: tb/tb_dsbpm_tbt_accumulator.sv
module tb_dsbpm_tbt_accumulator;
  localparam int CH   = 2;
  localparam int MAG  = 26;
  localparam int SITE = 100;
  localparam int SPTW = 7;
  localparam int ACC  = 33;
  localparam longint FS = 64'd67108863;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dsbpm_tbt_accumulator_if #(.CHANNEL_COUNT(CH), .MAG_WIDTH(MAG), .SPT_WIDTH(SPTW),
                             .ACC_WIDTH(ACC)) bus();

  dsbpm_tbt_accumulator #(.CHANNEL_COUNT(CH), .MAG_WIDTH(MAG),
                          .SITE_SAMPLES_PER_TURN(SITE)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct { longint t; longint d0; longint d1; int cnt; } tbt_t;
  tbt_t   tbt_q[$];
  longint miss_q[$];
  longint misp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int     m_mode = 0;   // 0 disabled, 1 waiting for sync, 2 running
  int     m_spt  = 0;
  int     m_n    = 0;
  int     m_turns = 0;
  longint m_sum[CH];
  bit     exp_synced = 1'b0;
  bit     exp_cfg    = 1'b0;

  bit cur_en  = 1'b0;
  int cur_spt = 4;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected or absent output at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_turns = 0;
    exp_synced = 1'b0; exp_cfg = 1'b0;
  endtask

  // Spec-level behaviour of one clock with the given inputs; stamp is the
  // time of the edge after which the resulting outputs become visible.
  task automatic model_step(bit en, int spt, bit v, bit mk, longint d0, longint d1,
                            longint stamp);
    bit bad;
    bad = (spt < 2) || (spt > SITE);
    if (!en) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      m_mode = 1; m_turns = 0; exp_cfg = bad;
    end else if (m_mode == 1) begin
      m_spt = spt;
      if (!bad && v && mk) begin
        m_sum[0] = d0; m_sum[1] = d1; m_n = 1; m_mode = 2;
      end
      exp_cfg = (m_mode == 1) && bad;
    end else if (v) begin
      if (m_n == 0 || mk) begin
        if (m_n == 0 && !mk) miss_q.push_back(stamp);
        if (m_n != 0 && mk)  misp_q.push_back(stamp);
        m_sum[0] = d0; m_sum[1] = d1; m_n = 1;
      end else begin
        m_sum[0] += d0; m_sum[1] += d1; m_n++;
      end
      if (m_n == m_spt) begin
        m_turns++;
        tbt_q.push_back('{stamp, m_sum[0], m_sum[1], m_turns});
        m_n = 0;
        m_spt = spt;
        if (bad) begin m_mode = 1; exp_cfg = 1'b1; end
      end
    end
    exp_synced = (m_mode == 2);
  endtask

  task automatic step(bit v, bit mk, longint d0, longint d1);
    @(negedge clk);
    bus.enable         = cur_en;
    bus.samplesPerTurn = SPTW'(cur_spt);
    bus.magValid       = v;
    bus.turnMarker     = mk;
    bus.magData        = {MAG'(d1), MAG'(d0)};
    model_step(cur_en, cur_spt, v, mk, d0, d1, longint'($time) + 5);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic sample(bit mk, longint d0, longint d1);
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    step(1'b1, mk, d0, d1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // monitor / scoreboard
  initial begin
    tbt_t   e;
    longint now;
    longint s;
    forever begin
      @(posedge clk);
      #2;
      now = longint'($time) - 2;
      if (bus.tbtValid) begin
        if (tbt_q.size() == 0) fail_evt("tbt_unexpected");
        else begin
          e = tbt_q.pop_front();
          chk("tbt_time", now, e.t);
          chk("tbt_ch0", bus.tbtData[ACC-1:0], e.d0);
          chk("tbt_ch1", bus.tbtData[2*ACC-1:ACC], e.d1);
          chk("tbt_count", bus.tbtTurnCount, e.cnt);
        end
      end
      if (bus.markerMissing) begin
        if (miss_q.size() == 0) fail_evt("missing_unexpected");
        else begin s = miss_q.pop_front(); chk("missing_time", now, s); end
      end
      if (bus.markerMisplaced) begin
        if (misp_q.size() == 0) fail_evt("misplaced_unexpected");
        else begin s = misp_q.pop_front(); chk("misplaced_time", now, s); end
      end
      while (tbt_q.size() > 0 && tbt_q[0].t < now) begin
        void'(tbt_q.pop_front()); fail_evt("tbt_absent");
      end
      while (miss_q.size() > 0 && miss_q[0] < now) begin
        void'(miss_q.pop_front()); fail_evt("missing_absent");
      end
      while (misp_q.size() > 0 && misp_q[0] < now) begin
        void'(misp_q.pop_front()); fail_evt("misplaced_absent");
      end
      chk("synced", bus.synced, exp_synced);
      chk("configError", bus.configError, exp_cfg);
      chk("turnCount", bus.tbtTurnCount, m_turns);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int period;
    bit v, mk;
    bus.enable = 1'b0; bus.samplesPerTurn = '0; bus.magValid = 1'b0;
    bus.turnMarker = 1'b0; bus.magData = '0;
    cur_en = 1'b0; cur_spt = 4;

    // reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_tbtValid", bus.tbtValid, 0);
    chk("rst_tbtData", bus.tbtData, 0);
    chk("rst_turnCount", bus.tbtTurnCount, 0);
    chk("rst_synced", bus.synced, 0);
    chk("rst_configError", bus.configError, 0);
    chk("rst_missing", bus.markerMissing, 0);
    chk("rst_misplaced", bus.markerMisplaced, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // nominal: spt 4, marker every 4th valid sample
    cur_en = 1'b1;
    idle(2);
    for (int i = 0; i < 12; i++) sample(i % 4 == 0, 1000, 2000);
    // one marker dropped: flywheel
    for (int i = 0; i < 16; i++) sample((i % 4 == 0) && (i != 8), 1000, 2000);
    settle();
    chk("flywheel_synced", bus.synced, 1);
    // marker injected at cnt 2
    begin
      bit pat[14] = '{1,0,1,0,0,0,1,0,0,0,1,0,0,0};
      for (int i = 0; i < 14; i++) sample(pat[i], 1000, 2000);
    end

    // invalid configs
    cur_en = 1'b0; idle(2);
    cur_spt = 1; cur_en = 1'b1;
    for (int i = 0; i < 8; i++) sample(i % 4 == 0, 1000, 2000);
    settle();
    chk("spt1_cfgerr", bus.configError, 1);
    chk("spt1_synced", bus.synced, 0);
    cur_spt = 101;
    for (int i = 0; i < 8; i++) sample(i % 4 == 0, 1000, 2000);
    settle();
    chk("spt101_cfgerr", bus.configError, 1);
    chk("spt101_synced", bus.synced, 0);
    // max turn length with full-scale input
    cur_spt = 100;
    idle(2);
    for (int i = 0; i < 100; i++) sample(i == 0, FS, FS);
    idle(1);
    settle();
    chk("fullscale_ch0", bus.tbtData[ACC-1:0], 100 * FS);
    chk("fullscale_ch1", bus.tbtData[2*ACC-1:ACC], 100 * FS);

    // enable dropped mid-turn
    for (int i = 0; i < 2; i++) sample(i == 0, 3, 4);
    cur_en = 1'b0;
    idle(1);
    settle();
    chk("drop_synced", bus.synced, 0);
    chk("drop_data_held", bus.tbtData[ACC-1:0], 100 * FS);
    cur_en = 1'b1; cur_spt = 4;
    idle(2);
    settle();
    chk("reenable_count", bus.tbtTurnCount, 0);
    for (int i = 0; i < 10; i++) sample(i == 2 || i == 6, 5, 7);

    // async reset mid-turn
    for (int i = 0; i < 3; i++) sample(i == 0, 9, 11);
    @(posedge clk);
    #3;
    rst = 1'b1; cur_en = 1'b0; bus.enable = 1'b0;
    model_reset();
    #1;
    chk("arst_tbtData", bus.tbtData, 0);
    chk("arst_turnCount", bus.tbtTurnCount, 0);
    chk("arst_synced", bus.synced, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // samplesPerTurn change 4 -> 6 mid-turn
    cur_en = 1'b1; cur_spt = 4;
    idle(1);
    sample(1, 21, 22);
    sample(0, 21, 22);
    cur_spt = 6;
    sample(0, 21, 22);
    sample(0, 21, 22);
    for (int i = 0; i < 12; i++) sample(i % 6 == 0, 30, 40);

    // randomized stream
    k = 0; period = cur_spt;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        cur_en = 1'b0; idle(1); cur_en = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: cur_spt = 0;
            1: cur_spt = 1;
            2: cur_spt = 101;
            default: cur_spt = 127;
          endcase
        end else begin
          cur_spt = $urandom_range(2, 8);
          period = cur_spt;
        end
      end
      v  = ($urandom_range(0, 3) != 0);
      mk = v && ((k % period) == 0);
      if ($urandom_range(0, 29) == 0) mk = !mk;
      if (v) k++;
      step(v, mk, longint'($urandom() & 32'h03FF_FFFF), longint'($urandom() & 32'h03FF_FFFF));
    end

    cur_en = 1'b0;
    idle(4);
    settle();
    chk("drain_tbt", tbt_q.size(), 0);
    chk("drain_missing", miss_q.size(), 0);
    chk("drain_misplaced", misp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dsbpm_tbt_accumulator.md
Name: dsbpm_tbt_accumulator

Overview:
- Multi-channel turn-by-turn (TBT) accumulator for the DSBPM signal chain.
- Sits after the per-channel magnitude stage and before the TBT/FA decimation and acquisition paths.
- Sums CHANNEL_COUNT magnitude streams over a runtime-programmable number of samples per turn, aligned to the EVR-derived turn marker.
- Adds flywheel operation through missing markers, resync on misplaced markers, and status strobes.

Parameters:
- CHANNEL_COUNT, 4, number of magnitude channels, 1..16.
- MAG_WIDTH, 26, unsigned magnitude width per channel.
- SITE_SAMPLES_PER_TURN, 100, maximum samples per turn.
- SPT_WIDTH, $clog2(SITE_SAMPLES_PER_TURN+1), width of the samplesPerTurn config input.
- ACC_WIDTH, MAG_WIDTH+$clog2(SITE_SAMPLES_PER_TURN), per-channel sum width; overflow is impossible by construction.

Ports:
- clk  in  1  ADC-domain clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  run enable; low forces IDLE.
- samplesPerTurn  in  SPT_WIDTH  runtime samples per turn.
- magValid  in  1  sample strobe.
- magData  in  CHANNEL_COUNT*MAG_WIDTH  packed magnitudes, channel 0 in the LSBs.
- turnMarker  in  1  qualified by magValid; marks the first sample of a turn.
- tbtValid  out  1  one-cycle strobe, tbtData valid.
- tbtData  out  CHANNEL_COUNT*ACC_WIDTH  packed per-channel turn sums.
- tbtTurnCount  out  32  turns emitted since leaving IDLE; wraps.
- markerMissing  out  1  one-cycle strobe.
- markerMisplaced  out  1  one-cycle strobe.
- configError  out  1  level.
- synced  out  1  level, high in RUN.

Behaviour:
- Reset and IDLE values: all outputs 0; state IDLE; accumulators, sample counter and tbtTurnCount cleared.
- Clocking: reset is asynchronous on assert and released synchronously through the usual 2-flop deassertion inside the block.
- States:
  - IDLE: stays while enable=0. On enable=1, goes to SYNC_WAIT and clears tbtTurnCount.
  - SYNC_WAIT: latches sptReg <= samplesPerTurn every cycle. configError = (samplesPerTurn<2 || samplesPerTurn>SITE_SAMPLES_PER_TURN); while it is set, the block stays in SYNC_WAIT and ignores markers. On magValid & turnMarker with config valid: load accumulators with the sample, cnt <= 1, go to RUN.
  - RUN: synced=1. Each magValid:
    - cnt==0 & turnMarker: load accumulators with the sample, cnt <= 1.
    - cnt==0 & !turnMarker: flywheel. Load the sample and cnt <= 1 as normal; pulse markerMissing.
    - cnt!=0 & turnMarker: pulse markerMisplaced. Discard the partial turn with no tbtValid; load the sample, cnt <= 1.
    - cnt!=0 & !turnMarker: acc += sample, cnt++.
    - If the updated cnt equals sptReg: register acc+sample into tbtData, assert tbtValid on the next cycle, tbtTurnCount++, cnt <= 0. At this turn boundary, re-latch sptReg from samplesPerTurn; an invalid value sends the block to SYNC_WAIT with configError.
    - Boundary vs marker: the boundary case ends a turn, so a marker on the following sample sees cnt==0 and is correct.
- Latency: tbtValid is 1 cycle after the magValid cycle carrying the last sample of the turn. tbtData holds until the next tbtValid.
- Status strobes: markerMissing and markerMisplaced are 1 cycle after the offending sample.
- Throughput: magValid may be high every cycle.
- enable=0 in any state: IDLE next cycle. Partial turn discarded, no tbtValid; tbtData retains its last value.
- samplesPerTurn changes mid-turn: take effect only at the next turn boundary or in SYNC_WAIT.
- Arithmetic: unsigned, zero-extend MAG_WIDTH to ACC_WIDTH, no rounding or saturation.
- Priority: rst > enable=0 > marker logic.

Decomposition:
- Shared package: CHANNEL_COUNT default, ACC_WIDTH function, state enumeration (IDLE=0, SYNC_WAIT=1, RUN=2), and status-bit indices for the register map (configError, synced, markerMissing/markerMisplaced sticky copies).
- Sub-module dsbpm_tbt_chan_acc: one per channel, generated. It holds the load/add/hold accumulator and output register, driven by load/add/commit controls from the top FSM.

Test Plan:
- samplesPerTurn=4, marker every 4th valid sample, magData ch0=1000, ch1=2000 constant, CHANNEL_COUNT=2 → tbtValid every 4 samples, tbtData {8000,4000}, tbtTurnCount 1,2,3, no status strobes.
- Same stream, one marker removed at turn 3 → markerMissing one pulse; turn 3 sum still 4000/8000; sync kept.
- Marker injected at cnt=2 of turn 2 → markerMisplaced pulse, no tbtValid for turn 2, next tbtValid 4 samples after the injected marker.
- samplesPerTurn=1 and =101 with default max → configError=1, synced=0, no tbtValid. Set to 100, marker, full-scale input (2^26-1) → sum 100*(2^26-1) exact.
- enable dropped at cnt=2 → no tbtValid, synced=0 next cycle. Re-enable: tbtTurnCount restarts at 0 and waits for a marker.
- rst asserted mid-turn asynchronously → outputs 0 immediately. samplesPerTurn changed 4→6 mid-turn: current turn uses 4, next uses 6.
